symm_operand_loader: RTL and testbench
======================================

SYMM_OPERAND_LOADER -- requirements
Module: symm_operand_loader

Interface
REQ-001 SHALL have parameter AUTO_IDENT, default 0: 1 = I operand generated internally as identity (32'h01000001), only 12 bytes loaded per job.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_data  input  8; in_valid  input  1; in_ready  output  1: byte stream of operand elements.
REQ-005 SHALL have ports op_a, op_b, op_c, op_i  output  32 each: packed 2x2 operands {x00,x01,x10,x11}, x00 in [31:24].
REQ-006 SHALL have ports op_valid  output  1; op_ready  input  1: operand issue handshake to the symm compute block.
REQ-007 SHALL have ports res_data  input  32; res_valid  input  1: packed result from compute block, same packing.
REQ-008 SHALL have ports out_data  output  8; out_valid  output  1; out_ready  input  1: result byte stream.
REQ-009 SHALL have ports busy  output  1 (state != LOAD or load count != 0); err  output  1 (sticky protocol error).

Function
REQ-010 SHALL implement FSM LOAD -> ISSUE -> WAIT -> DRAIN -> LOAD.
REQ-011 LOAD: in_ready=1; byte accepted when in_valid&in_ready; order A00,A01,A10,A11,B..,C..,I.. (I omitted if AUTO_IDENT=1).
REQ-012 Byte k of matrix m SHALL be written to bits [31-8k -: 8] of that operand register.
REQ-013 After the last byte (16th, or 12th if AUTO_IDENT) is accepted, SHALL enter ISSUE next cycle; in_ready=0 outside LOAD.
REQ-014 ISSUE: op_valid=1, op_a..op_i stable; on op_valid&op_ready SHALL go to WAIT; op_valid drops next cycle.
REQ-015 WAIT: on res_valid SHALL capture res_data into result register and go to DRAIN.
REQ-016 DRAIN: out_valid=1, out_data = result byte j, j=0..3 from [31:24] down; j advances on out_valid&out_ready; after j=3 accepted, SHALL return to LOAD with counters cleared.
REQ-017 Minimum latency: first byte out 1 cycle after res_valid capture; back-to-back drain at 1 byte/cycle when out_ready=1.
REQ-018 res_valid in any state other than WAIT SHALL be ignored and set err; err clears only by reset.
REQ-019 res_valid in the same cycle as the op handshake (ISSUE) SHALL be ignored and set err.
REQ-020 op_a..op_i SHALL hold their values from ISSUE until next job's first byte overwrites them.
REQ-021 All arithmetic on counters unsigned; load counter 4 bits, drain counter 2 bits, no wrap beyond terminal count.

Reset
REQ-022 On rst_n low (any time, including mid-load or mid-drain) SHALL asynchronously enter LOAD, clear counters, op_* = 0 (op_i = 32'h01000001 if AUTO_IDENT), result=0, op_valid=0, out_valid=0, out_data=0, in_ready=1 after release, busy=0, err=0.
REQ-023 Partially loaded job SHALL be discarded by reset; no output produced for it.

Structure
REQ-024 Shared package symm_pkg SHALL hold state enum, ELEM_W=8, N=2, WORD_W=32, IDENT_WORD=32'h01000001.
REQ-025 One sub-module symm_byte_pack (byte index + data -> 32-bit word update) SHALL be used for operand and result lanes; no other sub-modules.

Verification
REQ-026 Load bytes 01..10 hex (AUTO_IDENT=0), op_ready=1 -> op_a=01020304, op_b=05060708, op_c=090A0B0C, op_i=0D0E0F10, op_valid one cycle.
REQ-027 Stub returns res_data=11223344 3 cycles after issue, out_ready=1 -> out bytes 11,22,33,44 on 4 consecutive cycles, then in_ready=1.
REQ-028 out_ready toggled 1/0 each cycle during DRAIN -> each byte held stable until accepted, no loss or duplication.
REQ-029 AUTO_IDENT=1, 12 bytes loaded -> ISSUE after 12th byte, op_i=01000001.
REQ-030 rst_n pulsed low after 7 bytes loaded -> all outputs at reset values; next 16 bytes form a clean job.
REQ-031 res_valid asserted during LOAD -> err=1, state and outputs otherwise unaffected.

Source files
------------

// File: rtl/symm_pkg.sv
// Shared types and constants for the symm operand loader: state encoding,
// element/word geometry and the identity word used when I is generated internally.
package symm_pkg;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned N      = 2;
    localparam int unsigned WORD_W = ELEM_W * N * N;
    localparam int unsigned ELEMS  = N * N;

    localparam logic [WORD_W-1:0] IDENT_WORD = 32'h0100_0001;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic [3:0] last_load_idx(input bit auto_ident);
        return auto_ident ? 4'd11 : 4'd15;
    endfunction

endpackage

// File: rtl/symm_byte_pack.sv
// Next-value logic for one packed 2x2 word: whole-word load or a single element
// replaced in place, element 0 living in the top byte.
module symm_byte_pack
    import symm_pkg::*;
(
    input  logic [WORD_W-1:0] word_q,
    input  logic [1:0]        byte_idx,
    input  logic [ELEM_W-1:0] byte_data,
    input  logic              byte_we,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_we,
    output logic [WORD_W-1:0] word_d
);

    always_comb begin
        word_d = word_q;
        if (word_we) begin
            word_d = word_data;
        end else if (byte_we) begin
            for (int k = 0; k < ELEMS; k++) begin
                if (byte_idx == 2'(k)) begin
                    word_d[WORD_W-1-ELEM_W*k -: ELEM_W] = byte_data;
                end
            end
        end
    end

endmodule

// File: rtl/symm_operand_loader.sv
// Collects A/B/C/I operand bytes, issues them to the symm compute block,
// captures its packed result and streams it back out one byte at a time.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | accepting operand bytes, in_ready high
// ST_ISSUE | operands presented, op_valid high until op_ready
// ST_WAIT  | waiting for res_valid from the compute block
// ST_DRAIN | result bytes presented on out_data, out_valid high
module symm_operand_loader
    import symm_pkg::*;
#(
    parameter bit AUTO_IDENT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    output logic [WORD_W-1:0] op_c,
    output logic [WORD_W-1:0] op_i,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic [WORD_W-1:0] res_data,
    input  logic              res_valid,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] LAST_IDX = last_load_idx(AUTO_IDENT);

    state_t            state_q, state_d;
    logic [3:0]        load_cnt_q, load_cnt_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] op_q [ELEMS];
    logic [WORD_W-1:0] op_d [ELEMS];
    logic [WORD_W-1:0] result_q, result_d;
    logic              load_fire;
    logic              res_capture;

    assign load_fire   = (state_q == ST_LOAD) && in_valid;
    assign res_capture = (state_q == ST_WAIT) && res_valid;

    // Matrix select is load_cnt[3:2], element within the matrix is load_cnt[1:0].
    for (genvar g = 0; g < ELEMS; g++) begin : g_op
        localparam bit FIXED = AUTO_IDENT && (g == 3);
        localparam logic [WORD_W-1:0] RST_VAL = FIXED ? IDENT_WORD : '0;

        symm_byte_pack u_pack (
            .word_q    (op_q[g]),
            .byte_idx  (load_cnt_q[1:0]),
            .byte_data (in_data),
            .byte_we   (!FIXED && load_fire && (load_cnt_q[3:2] == 2'(g))),
            .word_data ('0),
            .word_we   (1'b0),
            .word_d    (op_d[g])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) op_q[g] <= RST_VAL;
            else        op_q[g] <= op_d[g];
        end
    end

    symm_byte_pack u_res_pack (
        .word_q    (result_q),
        .byte_idx  (2'd0),
        .byte_data ('0),
        .byte_we   (1'b0),
        .word_data (res_data),
        .word_we   (res_capture),
        .word_d    (result_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        // Any result outside WAIT, including one racing the issue handshake, is a protocol error.
        err_d       = err_q | (res_valid && (state_q != ST_WAIT));
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (load_cnt_q == LAST_IDX) begin
                        load_cnt_d = '0;
                        state_d    = ST_ISSUE;
                    end else begin
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (res_valid) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (drain_cnt_q == 2'd3) begin
                        drain_cnt_d = '0;
                        state_d     = ST_LOAD;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        out_data = '0;
        if (state_q == ST_DRAIN) begin
            for (int k = 0; k < ELEMS; k++) begin
                if (drain_cnt_q == 2'(k)) out_data = result_q[WORD_W-1-ELEM_W*k -: ELEM_W];
            end
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign op_valid  = (state_q == ST_ISSUE);
    assign out_valid = (state_q == ST_DRAIN);
    assign busy      = (state_q != ST_LOAD) || (load_cnt_q != 4'd0);
    assign err       = err_q;
    assign op_a      = op_q[0];
    assign op_b      = op_q[1];
    assign op_c      = op_q[2];
    assign op_i      = op_q[3];

endmodule

// File: tb/tb_symm_operand_loader.sv
// Directed bench for symm_operand_loader: one instance with a loaded I operand,
// one with the internally generated identity.
module tb_symm_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data0, in_data1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic [31:0] op_a0, op_b0, op_c0, op_i0;
    logic [31:0] op_a1, op_b1, op_c1, op_i1;
    logic        op_valid0, op_valid1;
    logic        op_ready0, op_ready1;
    logic [31:0] res_data0, res_data1;
    logic        res_valid0, res_valid1;
    logic [7:0]  out_data0, out_data1;
    logic        out_valid0, out_valid1;
    logic        out_ready0, out_ready1;
    logic        busy0, busy1;
    logic        err0, err1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    symm_operand_loader #(.AUTO_IDENT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .op_a(op_a0), .op_b(op_b0), .op_c(op_c0), .op_i(op_i0),
        .op_valid(op_valid0), .op_ready(op_ready0),
        .res_data(res_data0), .res_valid(res_valid0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .busy(busy0), .err(err0)
    );

    symm_operand_loader #(.AUTO_IDENT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .op_c(op_c1), .op_i(op_i1),
        .op_valid(op_valid1), .op_ready(op_ready1),
        .res_data(res_data1), .res_valid(res_valid1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1), .err(err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit d, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            if (d) begin in_data1 = first + 8'(i); in_valid1 = 1'b1; end
            else   begin in_data0 = first + 8'(i); in_valid0 = 1'b1; end
            step();
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    initial begin
        logic [31:0] res_word;
        int j;
        int cyc;

        rst_n = 1'b0;
        in_data0 = '0; in_valid0 = 1'b0; op_ready0 = 1'b0; res_data0 = '0; res_valid0 = 1'b0; out_ready0 = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0; op_ready1 = 1'b0; res_data1 = '0; res_valid1 = 1'b0; out_ready1 = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_op_a", op_a0, 32'h0);
        chk("rst_op_i", op_i0, 32'h0);
        chk("rst_op_valid", op_valid0, 0);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        chk("rst_op_i_ident", op_i1, 32'h0100_0001);

        // Job 1: bytes 01..10, result 11223344, out_ready held high
        op_ready0 = 1'b1;
        load(1'b0, 8'h01, 16);
        chk("j1_op_valid", op_valid0, 1);
        chk("j1_in_ready", in_ready0, 0);
        chk("j1_op_a", op_a0, 32'h0102_0304);
        chk("j1_op_b", op_b0, 32'h0506_0708);
        chk("j1_op_c", op_c0, 32'h090A_0B0C);
        chk("j1_op_i", op_i0, 32'h0D0E_0F10);
        step();
        chk("j1_op_valid_drop", op_valid0, 0);
        step();
        step();
        res_data0 = 32'h1122_3344; res_valid0 = 1'b1;
        out_ready0 = 1'b1;
        step();
        res_valid0 = 1'b0;
        res_word = 32'h1122_3344;
        for (int k = 0; k < 4; k++) begin
            chk("j1_out_valid", out_valid0, 1);
            chk("j1_out_data", out_data0, {24'h0, res_word[31-8*k -: 8]});
            step();
        end
        chk("j1_in_ready_after", in_ready0, 1);
        chk("j1_out_valid_after", out_valid0, 0);
        chk("j1_busy_after", busy0, 0);
        chk("j1_err", err0, 0);

        // Job 2: bytes 21..30, drain with out_ready alternating
        load(1'b0, 8'h21, 16);
        chk("j2_op_a", op_a0, 32'h2122_2324);
        step();
        res_data0 = 32'hAABB_CCDD; res_valid0 = 1'b1;
        step();
        res_valid0 = 1'b0;
        res_word = 32'hAABB_CCDD;
        j = 0;
        cyc = 0;
        while (j < 4 && cyc < 16) begin
            chk("j2_out_valid", out_valid0, 1);
            chk("j2_out_data", out_data0, {24'h0, res_word[31-8*j -: 8]});
            out_ready0 = cyc[0];
            step();
            if (out_ready0) j++;
            cyc++;
        end
        chk("j2_drain_count", j, 4);
        chk("j2_drain_cycles", cyc, 8);
        out_ready0 = 1'b1;
        chk("j2_in_ready_after", in_ready0, 1);
        chk("j2_op_b_hold", op_b0, 32'h2526_2728);

        // Job 3: 7 bytes then reset; partial job discarded
        load(1'b0, 8'h40, 7);
        chk("j3_op_a_partial", op_a0, 32'h4041_4243);
        chk("j3_op_b_partial", op_b0, 32'h4445_4628);
        chk("j3_busy_partial", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("j3_rst_op_a", op_a0, 32'h0);
        chk("j3_rst_op_b", op_b0, 32'h0);
        chk("j3_rst_busy", busy0, 0);
        chk("j3_rst_out_valid", out_valid0, 0);
        step();
        rst_n = 1'b1;
        chk("j3_rst_in_ready", in_ready0, 1);

        // Job 4: clean 16-byte job after reset, op_ready held off one cycle
        op_ready0 = 1'b0;
        load(1'b0, 8'h51, 16);
        chk("j4_op_valid", op_valid0, 1);
        chk("j4_op_b", op_b0, 32'h5556_5758);
        chk("j4_op_i", op_i0, 32'h5D5E_5F60);
        step();
        chk("j4_op_valid_held", op_valid0, 1);
        op_ready0 = 1'b1;
        step();
        chk("j4_op_valid_drop", op_valid0, 0);
        chk("j4_busy_wait", busy0, 1);
        res_data0 = 32'h0F1E_2D3C; res_valid0 = 1'b1;
        step();
        res_valid0 = 1'b0;
        chk("j4_out_data0", out_data0, 32'h0F);
        step();
        step();
        step();
        chk("j4_out_data3", out_data0, 32'h3C);
        step();
        chk("j4_busy_done", busy0, 0);
        chk("j4_err_clean", err0, 0);

        // Stray result while loading: sticky error, nothing else moves
        res_data0 = 32'hFFFF_FFFF; res_valid0 = 1'b1;
        step();
        res_valid0 = 1'b0;
        chk("stray_err", err0, 1);
        chk("stray_in_ready", in_ready0, 1);
        chk("stray_out_valid", out_valid0, 0);
        chk("stray_busy", busy0, 0);
        chk("stray_op_a", op_a0, 32'h5152_5354);
        step();
        chk("stray_err_sticky", err0, 1);

        // Identity instance: 12 bytes, result racing the issue handshake
        op_ready1 = 1'b1;
        load(1'b1, 8'h01, 12);
        chk("id_op_valid", op_valid1, 1);
        chk("id_in_ready", in_ready1, 0);
        chk("id_op_a", op_a1, 32'h0102_0304);
        chk("id_op_c", op_c1, 32'h090A_0B0C);
        chk("id_op_i", op_i1, 32'h0100_0001);
        chk("id_err_pre", err1, 0);
        res_data1 = 32'hDEAD_BEEF; res_valid1 = 1'b1;
        step();
        res_valid1 = 1'b0;
        chk("id_race_err", err1, 1);
        chk("id_race_ignored", out_valid1, 0);
        chk("id_race_op_valid", op_valid1, 0);
        res_data1 = 32'hC1C2_C3C4; res_valid1 = 1'b1;
        step();
        res_valid1 = 1'b0;
        chk("id_out_valid", out_valid1, 1);
        chk("id_out_data0", out_data1, 32'hC1);
        out_ready1 = 1'b1;
        step();
        chk("id_out_data1", out_data1, 32'hC2);
        step();
        step();
        step();
        chk("id_in_ready_after", in_ready1, 1);
        chk("id_busy_after", busy1, 0);
        chk("id_op_i_hold", op_i1, 32'h0100_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
